usb2_ts_packer: RTL
===================

USB2_TS_PACKER -- requirements
Module: usb2_ts_packer

Interface
REQ-001 SHALL have parameter PKTS_PER_XFER, default 5, meaning the number of 188-byte TS packets per endpoint-3 commit (1..5).
REQ-002 SHALL have parameter FLUSH_TIMEOUT, default 16'd50000, meaning idle cycles before a partial buffer is committed.
REQ-003 SHALL have ports:
- phy_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- ts_data  in  8  TS byte.
- ts_valid  in  1  byte strobe.
- ts_start  in  1  first byte of a packet, qualified by ts_valid.
- buf_in_addr  out  11  EP3 write address.
- buf_in_data  out  8  EP3 write data.
- buf_in_wren  out  1  EP3 write enable.
- buf_in_ready  in  1  EP3 buffer free.
- buf_in_commit  out  1  commit request.
- buf_in_commit_len  out  11  committed byte count.
- buf_in_commit_ack  in  1  commit accepted.
- pkt_drop  out  1  one-cycle pulse per dropped packet.

Function
REQ-004 SHALL implement states IDLE, FILL, SKIP, COMMIT, WAIT_ACK.
REQ-005 IDLE: on ts_valid&ts_start with ts_data==8'h47 and buf_in_ready=1, SHALL write the byte and go to FILL.
- Same event with buf_in_ready=0 or ts_data!=8'h47: SHALL pulse pkt_drop and go to SKIP.
REQ-006 FILL: each ts_valid byte SHALL be written in the same cycle at addr = base + byte index, with wren=1 for exactly that cycle.
- base = committed-packet count in this transfer × 188.
REQ-007 A ts_start received in FILL before byte 188 SHALL abort the current packet (base unchanged) and be treated as a new start per REQ-005.
REQ-008 On byte 188, SHALL increment pkt_cnt.
- pkt_cnt==PKTS_PER_XFER: go to COMMIT.
- Otherwise: return to IDLE.
REQ-009 SKIP: SHALL ignore bytes until the next ts_start, then evaluate it per REQ-005.
REQ-010 COMMIT: SHALL assert buf_in_commit=1 with buf_in_commit_len=pkt_cnt×188 and go to WAIT_ACK.
REQ-011 WAIT_ACK: SHALL hold commit and len until buf_in_commit_ack=1, then deassert commit, clear pkt_cnt and base, and go to IDLE.
REQ-012 Bytes arriving in COMMIT/WAIT_ACK SHALL not be written.
- Any packet started there SHALL be dropped (one pkt_drop pulse) and SKIP entered after the ack.
REQ-013 An idle counter SHALL count cycles in IDLE with pkt_cnt>0, reset on any ts_valid.
- On reaching FLUSH_TIMEOUT: go to COMMIT with the partial count.
- With pkt_cnt==0: never commit.
REQ-014 Arithmetic SHALL be 11-bit; the maximum address is 5×188−1=939, so there is no wrap.

Reset
REQ-015 Async reset_n low SHALL force state IDLE, pkt_cnt=0, idle counter=0, buf_in_wren=0, buf_in_commit=0, buf_in_commit_len=0, buf_in_addr=0, buf_in_data=0, pkt_drop=0.
REQ-016 Reset during WAIT_ACK SHALL abandon the commit with no further handshake.

Configuration
REQ-017 With TS_PACKER_STATS_EN defined, SHALL add outputs:
- stat_xfers  out  16  commits completed, incremented on ack.
- stat_drops  out  16  pkt_drop pulses.
- Both saturate at 16'hFFFF and reset to 0.
- Without the macro, these ports and counters SHALL not exist.

Structure
REQ-018 TS_PKT_LEN=188, TS_SYNC=8'h47 and the state encoding SHALL live in shared package usb2_ts_pkg.
REQ-019 The idle/flush counter SHALL be a sub-module usb2_ts_flush_timer (clear, enable, expire).

Verification
REQ-020 Bench SHALL cover the following scenarios:
- 5 valid packets, back-to-back, ack 3 cycles after commit -> addresses 0..939 written once each, commit_len=940, one commit.
- 2 packets then 50000 idle cycles -> commit_len=376 on cycle 50000.
- Packet with first byte 8'h46 -> pkt_drop pulse, no writes until the next valid start.
- buf_in_ready=0 at packet start -> drop pulse; next packet with ready=1 written at addr base 0.
- ts_start at byte 100 of packet 2 -> packet 2 rewritten from addr 188; final len counts only complete packets.
- reset_n low during WAIT_ACK -> commit=0 asynchronously, next transfer starts at addr 0.

Source files
------------

// File: rtl/usb2_ts_pkg.sv
// ----------------------------------------------------------------------------
// usb2_ts_pkg
// Shared constants, FSM state encoding and a byte-count helper for the
// MPEG-TS to USB2 endpoint-3 packer (usb2_ts_packer, usb2_ts_flush_timer).
// ----------------------------------------------------------------------------
package usb2_ts_pkg;

  localparam logic [10:0] TS_PKT_LEN      = 11'd188;
  localparam logic [7:0]  TS_PKT_LAST_IDX = 8'd187;
  localparam logic [7:0]  TS_SYNC         = 8'h47;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_SKIP     = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_WAIT_ACK = 3'd4
  } ts_state_e;

  // Byte count of a number of complete TS packets; never exceeds 940.
  function automatic logic [10:0] pkt_bytes(input logic [2:0] cnt);
    return 11'(cnt) * TS_PKT_LEN;
  endfunction

endpackage

// File: rtl/usb2_ts_flush_timer.sv
// ----------------------------------------------------------------------------
// usb2_ts_flush_timer
// Counts enabled cycles; expire is high on the TIMEOUT-th consecutive
// enabled cycle that is not also a clear cycle.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clear       synchronous clear of the count (wins over enable)
//   enable      count this cycle
//   expire      combinational: this cycle completes TIMEOUT enabled cycles
// ----------------------------------------------------------------------------
module usb2_ts_flush_timer #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] cnt_q;

  assign expire = enable && !clear && (cnt_q == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else if (clear) begin
      cnt_q <= 16'd0;
    end else if (enable && !expire) begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples pre-edge values regardless of statement order.
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/usb2_ts_packer.sv
// ----------------------------------------------------------------------------
// usb2_ts_packer
// Packs 188-byte MPEG-TS packets into the USB2 endpoint-3 IN buffer and
// commits the buffer after PKTS_PER_XFER packets, or earlier when the stream
// goes idle for FLUSH_TIMEOUT cycles with at least one packet buffered.
// Packets with a bad sync byte, or starting while the buffer is busy or not
// ready, are dropped whole.
// Ports:
//   phy_clk, reset_n           clock / async active-low reset
//   ts_data/ts_valid/ts_start  TS byte stream (ts_start marks byte 0)
//   buf_in_addr/data/wren      registered EP3 buffer write port
//   buf_in_ready               EP3 buffer free
//   buf_in_commit/_len/_ack    commit handshake (held until ack)
//   pkt_drop                   one-cycle pulse per dropped packet
//   stat_xfers/stat_drops      saturating counters, only when the macro
//                              TS_PACKER_STATS_EN is defined
// ----------------------------------------------------------------------------
module usb2_ts_packer
  import usb2_ts_pkg::*;
#(
  parameter int          PKTS_PER_XFER = 5,
  parameter logic [15:0] FLUSH_TIMEOUT = 16'd50000
) (
  input  logic        phy_clk,
  input  logic        reset_n,
  input  logic [7:0]  ts_data,
  input  logic        ts_valid,
  input  logic        ts_start,
  output logic [10:0] buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  input  logic        buf_in_ready,
  output logic        buf_in_commit,
  output logic [10:0] buf_in_commit_len,
  input  logic        buf_in_commit_ack,
  output logic        pkt_drop
`ifdef TS_PACKER_STATS_EN
  ,
  output logic [15:0] stat_xfers,
  output logic [15:0] stat_drops
`endif
);

  ts_state_e   state_q;
  logic [2:0]  pkt_cnt_q;
  logic [7:0]  byte_idx_q;
  logic [10:0] base_q;
  logic        drop_pend_q;   // a packet started while the commit was pending

  logic sop, start_ok, last_byte;
  logic tmr_clear, tmr_enable, flush_expire;

  assign sop       = ts_valid && ts_start;
  assign start_ok  = (ts_data == TS_SYNC) && buf_in_ready;
  assign last_byte = (byte_idx_q == TS_PKT_LAST_IDX);

  // Idle time only matters while a partial transfer is sitting in the buffer.
  assign tmr_enable = (state_q == ST_IDLE) && (pkt_cnt_q != 3'd0);
  assign tmr_clear  = ts_valid || !tmr_enable;

  usb2_ts_flush_timer #(.TIMEOUT(FLUSH_TIMEOUT)) u_flush_timer (
    .clk    (phy_clk),
    .rst_n  (reset_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expire (flush_expire)
  );

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      pkt_cnt_q         <= 3'd0;
      byte_idx_q        <= 8'd0;
      base_q            <= 11'd0;
      drop_pend_q       <= 1'b0;
      buf_in_addr       <= 11'd0;
      buf_in_data       <= 8'd0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= 11'd0;
      pkt_drop          <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; branches below only raise
      // them, which keeps wren and pkt_drop single-cycle by construction.
      buf_in_wren <= 1'b0;
      pkt_drop    <= 1'b0;

      if (sop && (state_q inside {ST_IDLE, ST_FILL, ST_SKIP})) begin
        // New packet start; in FILL this also aborts the partial packet,
        // which is simply overwritten since base_q has not moved.
        if (start_ok) begin
          buf_in_addr <= base_q;
          buf_in_data <= ts_data;
          buf_in_wren <= 1'b1;
          byte_idx_q  <= 8'd1;
          state_q     <= ST_FILL;
        end else begin
          pkt_drop <= 1'b1;
          state_q  <= ST_SKIP;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (flush_expire) state_q <= ST_COMMIT;
          end

          ST_FILL: begin
            if (ts_valid) begin
              buf_in_addr <= base_q + 11'(byte_idx_q);
              buf_in_data <= ts_data;
              buf_in_wren <= 1'b1;
              if (last_byte) begin
                byte_idx_q <= 8'd0;
                pkt_cnt_q  <= pkt_cnt_q + 3'd1;
                base_q     <= base_q + TS_PKT_LEN;
                state_q    <= (pkt_cnt_q + 3'd1 == 3'(PKTS_PER_XFER)) ? ST_COMMIT : ST_IDLE;
              end else begin
                byte_idx_q <= byte_idx_q + 8'd1;
              end
            end
          end

          ST_SKIP: ;

          ST_COMMIT: begin
            buf_in_commit     <= 1'b1;
            buf_in_commit_len <= pkt_bytes(pkt_cnt_q);
            state_q           <= ST_WAIT_ACK;
            if (sop) begin
              pkt_drop    <= 1'b1;
              drop_pend_q <= 1'b1;
            end
          end

          ST_WAIT_ACK: begin
            if (sop) pkt_drop <= 1'b1;
            if (buf_in_commit_ack) begin
              buf_in_commit <= 1'b0;
              pkt_cnt_q     <= 3'd0;
              base_q        <= 11'd0;
              drop_pend_q   <= 1'b0;
              // The tail of a packet dropped here must not be mistaken for data.
              state_q       <= (drop_pend_q || sop) ? ST_SKIP : ST_IDLE;
            end else if (sop) begin
              drop_pend_q <= 1'b1;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TS_PACKER_STATS_EN
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_xfers <= 16'd0;
      stat_drops <= 16'd0;
    end else begin
      if ((state_q == ST_WAIT_ACK) && buf_in_commit_ack && (stat_xfers != 16'hFFFF))
        stat_xfers <= stat_xfers + 16'd1;
      if (pkt_drop && (stat_drops != 16'hFFFF))
        stat_drops <= stat_drops + 16'd1;
    end
  end
`endif

endmodule
